// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types for the memory port arbiter
// Contents: XLEN, the response owner enum, and the in-flight access record.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {OWN_IF, OWN_LSU} mem_owner_e;

  typedef struct packed {
    logic       valid;
    mem_owner_e owner;
    logic       is_store;
  } mem_inflight_t;

endpackage

// File: rtl/mem_resp_tracker.sv
// rtl/mem_resp_tracker.sv - MEM_LAT-deep owner pipeline and read response demux
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   push_valid_i/owner/store   access granted this cycle and who issued it
//   mem_rdata_i                memory read data, aligned with the pipeline tail
//   if_rvalid_o/if_rdata_o     IF response
//   lsu_rvalid_o/lsu_rdata_o   LSU response (rdata 0 for store acks)
module mem_resp_tracker
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push_valid_i,
  input  mem_owner_e      push_owner_i,
  input  logic            push_store_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o
);

  mem_inflight_t r_pipe [MEM_LAT];
  mem_inflight_t w_push;
  mem_inflight_t w_tail;

  assign w_push = '{valid: push_valid_i, owner: push_owner_i, is_store: push_store_i};
  assign w_tail = r_pipe[MEM_LAT-1];

  // Entry pushed at the grant edge reaches the tail exactly MEM_LAT cycles later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_push;
      for (int i = 1; i < MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // rstn gating keeps responses silent during the reset cycle itself.
  assign if_rvalid_o  = rstn && w_tail.valid && (w_tail.owner == OWN_IF);
  assign lsu_rvalid_o = rstn && w_tail.valid && (w_tail.owner == OWN_LSU);
  assign if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
  assign lsu_rdata_o  = (lsu_rvalid_o && !w_tail.is_store) ? mem_rdata_i : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LSU arbiter for the shared memory port
// Option macro: MEM_ARB_RR_EN selects round-robin; default is LSU priority
// with a starvation guard that forces IF after STARVE_MAX LSU wins.
// Ports:
//   clk, rstn                            clock, synchronous active-low reset
//   if_req_i/if_addr_i/if_gnt_o          IF request side
//   if_rvalid_o/if_rdata_o               IF response
//   lsu_req_i/we/be/addr/wdata, gnt      LSU request side
//   lsu_rvalid_o/lsu_rdata_o             LSU response
//   mem_req_o/we/be/addr/wdata           memory strobe and command
//   mem_rdata_i                          memory data, MEM_LAT cycles after mem_req_o
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [XLEN/8-1:0] lsu_be_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  logic w_if_gnt;
  logic w_lsu_gnt;

`ifdef MEM_ARB_RR_EN
  mem_owner_e r_last_owner;

  // On a tie the requester that did not win last time is granted.
  assign w_lsu_gnt = rstn && lsu_req_i && (!if_req_i || (r_last_owner == OWN_IF));
  assign w_if_gnt  = rstn && if_req_i && !w_lsu_gnt;

  always_ff @(posedge clk) begin
    if (!rstn)          r_last_owner <= OWN_IF;
    else if (w_lsu_gnt) r_last_owner <= OWN_LSU;
    else if (w_if_gnt)  r_last_owner <= OWN_IF;
  end
`else
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          w_force_if;

  assign w_force_if = (r_starve_cnt == CW'(STARVE_MAX));
  assign w_lsu_gnt  = rstn && lsu_req_i && !(if_req_i && w_force_if);
  assign w_if_gnt   = rstn && if_req_i && !w_lsu_gnt;

  // Counts LSU wins while IF is left waiting; any IF win or idle IF clears it.
  always_ff @(posedge clk) begin
    if (!rstn || !if_req_i || w_if_gnt) r_starve_cnt <= '0;
    else if (w_lsu_gnt && !w_force_if)  r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`endif

  assign if_gnt_o  = w_if_gnt;
  assign lsu_gnt_o = w_lsu_gnt;

  assign mem_req_o   = w_if_gnt | w_lsu_gnt;
  assign mem_we_o    = w_lsu_gnt & lsu_we_i;
  assign mem_be_o    = w_lsu_gnt ? lsu_be_i    : (w_if_gnt ? '1 : '0);
  assign mem_addr_o  = w_lsu_gnt ? lsu_addr_i  : (w_if_gnt ? if_addr_i : '0);
  assign mem_wdata_o = w_lsu_gnt ? lsu_wdata_i : '0;

  always_ff @(posedge clk) begin
    if (rstn) assert (!(w_if_gnt && w_lsu_gnt));
  end

  mem_resp_tracker #(
    .XLEN    (XLEN),
    .MEM_LAT (MEM_LAT)
  ) u_tracker (
    .clk          (clk),
    .rstn         (rstn),
    .push_valid_i (mem_req_o),
    .push_owner_i (w_lsu_gnt ? OWN_LSU : OWN_IF),
    .push_store_i (mem_we_o),
    .mem_rdata_i  (mem_rdata_i),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench, three DUTs with MEM_LAT 1, 2, 3
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [3:0]  lsu_be = 4'hF;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;

  logic [2:0]  if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, mem_req, mem_we;
  logic [31:0] if_rdata [3];
  logic [31:0] lsu_rdata [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic [3:0]  mem_be [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_port_arbiter #(.XLEN(32), .MEM_LAT(k + 1), .STARVE_MAX(4)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .if_req_i     (if_req),
      .if_addr_i    (if_addr),
      .if_gnt_o     (if_gnt[k]),
      .if_rvalid_o  (if_rvalid[k]),
      .if_rdata_o   (if_rdata[k]),
      .lsu_req_i    (lsu_req),
      .lsu_we_i     (lsu_we),
      .lsu_be_i     (lsu_be),
      .lsu_addr_i   (lsu_addr),
      .lsu_wdata_i  (lsu_wdata),
      .lsu_gnt_o    (lsu_gnt[k]),
      .lsu_rvalid_o (lsu_rvalid[k]),
      .lsu_rdata_o  (lsu_rdata[k]),
      .mem_req_o    (mem_req[k]),
      .mem_we_o     (mem_we[k]),
      .mem_be_o     (mem_be[k]),
      .mem_addr_o   (mem_addr[k]),
      .mem_wdata_o  (mem_wdata[k]),
      .mem_rdata_i  (mem_rdata[k])
    );

    // Small word memory: unwritten words read a fixed pattern, word 4 holds an instruction.
    logic [31:0] mem [16];
    logic [15:0] written = '0;
    logic [31:0] rpipe [3];
    logic [3:0]  idx;
    logic [31:0] rdv;
    logic [31:0] wv;

    assign idx = mem_addr[k][5:2];
    assign rdv = written[idx] ? mem[idx] : ((idx == 4'd4) ? 32'h00500093 : (32'h1000_0000 + {28'd0, idx}));

    always_comb begin
      wv = rdv;
      for (int b = 0; b < 4; b++) if (mem_be[k][b]) wv[8*b +: 8] = mem_wdata[k][8*b +: 8];
    end

    always @(posedge clk) begin
      if (mem_req[k] && mem_we[k]) begin
        mem[idx]     <= wv;
        written[idx] <= 1'b1;
      end
      rpipe[0] <= rdv;
      rpipe[1] <= rpipe[0];
      rpipe[2] <= rpipe[1];
    end

    assign mem_rdata[k] = rpipe[k];
  end

`ifdef MEM_ARB_RR_EN
  localparam logic [6:0] LSU_SEQ = 7'b1010101;
`else
  localparam logic [6:0] LSU_SEQ = 7'b1101111;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if_req = 1'b0;
      lsu_req = 1'b0;
      lsu_we = 1'b0;
      mid();
    end
  endtask

  initial begin
    logic [6:0] seq;
    seq = LSU_SEQ;

    // Test 1: reset holds all outputs low even with both requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      rstn = 1'b0; if_req = 1'b1; lsu_req = 1'b1;
      mid();
      check("rst_gnt", {26'd0, if_gnt, lsu_gnt}, 32'd0);
      check("rst_memreq_rvalid", {23'd0, mem_req, if_rvalid, lsu_rvalid}, 32'd0);
    end
    tick();
    rstn = 1'b1;
    mid();
    check("first_gnt_lsu", {29'd0, lsu_gnt}, 32'd7);
    check("first_gnt_if", {29'd0, if_gnt}, 32'd0);
    idle(4);

    // Test 2: IF-only fetch, MEM_LAT = 1
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    mid();
    check("if_gnt", {31'd0, if_gnt[0]}, 32'd1);
    check("if_memaddr", mem_addr[0], 32'h0000_0010);
    check("if_be_we", {27'd0, mem_be[0], mem_we[0]}, 32'h1E);
    tick();
    if_req = 1'b0;
    mid();
    check("if_rvalid", {30'd0, if_rvalid[0], lsu_rvalid[0]}, 32'd2);
    check("if_rdata", if_rdata[0], 32'h00500093);
    idle(4);

    // Test 3: continuous contention
    for (int c = 0; c < 7; c++) begin
      tick();
      if_req = 1'b1; lsu_req = 1'b1; lsu_addr = 32'h0;
      mid();
      check($sformatf("cont_lsu_%0d", c), {31'd0, lsu_gnt[0]}, {31'd0, seq[c]});
      check($sformatf("cont_if_%0d", c), {31'd0, if_gnt[0]}, {31'd0, ~seq[c]});
    end
    idle(4);

    // Test 4: store then back-to-back load on MEM_LAT = 1
    tick();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h4; lsu_wdata = 32'hDEADBEEF;
    mid();
    check("st_gnt_we", {30'd0, lsu_gnt[0], mem_we[0]}, 32'd3);
    check("st_wdata", mem_wdata[0], 32'hDEADBEEF);
    tick();
    lsu_we = 1'b0;
    mid();
    check("st_ack_valid", {31'd0, lsu_rvalid[0]}, 32'd1);
    check("st_ack_data", lsu_rdata[0], 32'd0);
    tick();
    lsu_req = 1'b0;
    mid();
    check("ld_valid", {31'd0, lsu_rvalid[0]}, 32'd1);
    check("ld_data", lsu_rdata[0], 32'hDEADBEEF);
    idle(4);

    // Test 5: alternating IF/LSU grants on MEM_LAT = 3
    for (int c = 0; c < 9; c++) begin
      tick();
      if_req  = (c < 6) && (c % 2 == 0);
      lsu_req = (c < 6) && (c % 2 == 1);
      if_addr = 32'h10; lsu_addr = 32'h4;
      mid();
      if (c < 6) check($sformatf("alt_gnt_%0d", c), {30'd0, if_gnt[2], lsu_gnt[2]}, (c % 2 == 0) ? 32'd2 : 32'd1);
      if (c < 3) begin
        check($sformatf("alt_quiet_%0d", c), {30'd0, if_rvalid[2], lsu_rvalid[2]}, 32'd0);
      end else if ((c - 3) % 2 == 0) begin
        check($sformatf("alt_rv_%0d", c), {30'd0, if_rvalid[2], lsu_rvalid[2]}, 32'd2);
        check($sformatf("alt_if_data_%0d", c), if_rdata[2], 32'h00500093);
      end else begin
        check($sformatf("alt_rv_%0d", c), {30'd0, if_rvalid[2], lsu_rvalid[2]}, 32'd1);
        check($sformatf("alt_lsu_data_%0d", c), lsu_rdata[2], 32'hDEADBEEF);
      end
    end
    idle(4);

    // Test 6: reset right after an LSU load on MEM_LAT = 2 drops the response
    for (int c = 0; c < 4; c++) begin
      tick();
      if_req = 1'b1; lsu_req = 1'b1; lsu_addr = 32'h4;
      mid();
    end
    check("pre_rst_lsu_gnt", {31'd0, lsu_gnt[1]}, 32'd1);
    tick();
    rstn = 1'b0;
    mid();
    check("rst6_quiet", {28'd0, if_gnt[1], lsu_gnt[1], mem_req[1], lsu_rvalid[1]}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      rstn = 1'b1;
      mid();
      if (c == 0) check("rst6_dropped", {31'd0, lsu_rvalid[1]}, 32'd0);
      check($sformatf("post_rst_lsu_%0d", c), {31'd0, lsu_gnt[1]}, {31'd0, seq[c]});
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
